// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: runs one req/gnt/rvalid bus transaction per load or store,
// stalls the pipeline while it is in flight and formats load data for MEM/WB.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, stateNext;
  logic [7:0]  toCnt;
  logic [31:0] addrQ, wdataQ, rdataQ;
  logic [3:0]  wstrbQ;
  logic        weQ, errQ;
  logic [2:0]  funct3Q;

  logic        access, legal, misal, bad, acc, timeoutHit;
  logic [31:0] stWdata, shifted, loadFmt;
  logic [3:0]  stWstrb;
  logic [15:0] halfSel;

  assign access = MemReadM | MemWriteM;

  always_comb begin
    legal = 1'b0;
    case (Funct3M)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = MemReadM;
      default:                legal = 1'b0;
    endcase
  end

  assign misal = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                 ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
  assign bad   = ~legal | misal;
  assign acc   = access & ~bad;

  always_comb begin
    stWdata = WriteDataM;
    stWstrb = 4'hF;
    case (Funct3M[1:0])
      2'b00: begin
        stWdata = {4{WriteDataM[7:0]}};
        stWstrb = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        stWdata = {2{WriteDataM[15:0]}};
        stWstrb = 4'b0011 << {ALUResultM[1], 1'b0};
      end
      default: begin
        stWdata = WriteDataM;
        stWstrb = 4'hF;
      end
    endcase
  end

  // The same counter serves the grant wait and the read-data wait.
  assign timeoutHit = (toCnt == TO_LAST);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (acc) stateNext = REQ;
      REQ: begin
        if (bus_gnt)         stateNext = weQ ? DONE : WAIT;
        else if (timeoutHit) stateNext = DONE;
      end
      WAIT: if (bus_rvalid || timeoutHit) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      toCnt   <= 8'd0;
      addrQ   <= 32'd0;
      wdataQ  <= 32'd0;
      rdataQ  <= 32'd0;
      wstrbQ  <= 4'd0;
      weQ     <= 1'b0;
      errQ    <= 1'b0;
      funct3Q <= 3'd0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (acc) begin
            addrQ   <= ALUResultM;
            weQ     <= MemWriteM;
            funct3Q <= Funct3M;
            wdataQ  <= stWdata;
            wstrbQ  <= MemWriteM ? stWstrb : 4'd0;
            toCnt   <= 8'd0;
            errQ    <= 1'b0;
            rdataQ  <= 32'd0;
          end
        end
        REQ: begin
          if (bus_gnt) begin
            toCnt <= 8'd0;
          end else begin
            toCnt <= toCnt + 8'd1;
            if (timeoutHit) errQ <= 1'b1;
          end
        end
        WAIT: begin
          toCnt <= toCnt + 8'd1;
          if (bus_rvalid)      rdataQ <= bus_rdata;
          else if (timeoutHit) errQ   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign shifted = rdataQ >> {addrQ[1:0], 3'b000};
  assign halfSel = addrQ[1] ? rdataQ[31:16] : rdataQ[15:0];

  always_comb begin
    case (funct3Q)
      3'b000:  loadFmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  loadFmt = {24'd0, shifted[7:0]};
      3'b001:  loadFmt = {{16{halfSel[15]}}, halfSel};
      3'b101:  loadFmt = {16'd0, halfSel};
      default: loadFmt = rdataQ;
    endcase
  end

  // StallM/MisalignM are combinational on the inputs, so force them low during reset.
  assign StallM    = ~reset & (((state == IDLE) & acc) | (state == REQ) | (state == WAIT));
  assign MisalignM = ~reset & (state == IDLE) & access & bad;
  assign BusErrM   = (state == DONE) & errQ;
  assign ReadDataM = (state == DONE) ? loadFmt : 32'd0;

  assign bus_req   = (state == REQ);
  assign bus_we    = weQ;
  assign bus_addr  = {addrQ[31:2], 2'b00};
  assign bus_wdata = wdataQ;
  assign bus_wstrb = wstrbQ;

endmodule
